// File: rtl/ptw_mem_arbiter_pkg.sv
// Shared definitions for the PTW memory arbiter: FSM state codes, grant index type, AXI OKAY code.
// These are the PtwArbStruct definitions shared by the immu/dmmu walker paths.
package ptw_mem_arbiter_pkg;

   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t ADDR = 2'd1;
   localparam state_t DATA = 2'd2;
   localparam state_t DONE = 2'd3;

   // 0 = immu walker, 1 = dmmu walker
   typedef logic grant_t;

   localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ptw_mem_arbiter_pick.sv
// Combinational grant selection between the two walkers.
// PTW_ARB_RR_EN selects round-robin on ties; otherwise dmmu has fixed priority.
module ptw_arb_pick
   import ptw_mem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  grant_t     last,
   output grant_t     grant,
   output logic       grant_vld
);

   assign grant_vld = |req;

`ifdef PTW_ARB_RR_EN
   // On a tie the walker that was not granted last time wins.
   always_comb begin
      grant = req[1];
      if (req == 2'b11)
         grant = ~last;
   end
`else
   logic unused_last;
   assign unused_last = last;
   assign grant       = req[1];
`endif

endmodule

// File: rtl/ptw_mem_arbiter.sv
// Shares one read-only valid/ready memory channel between the immu and dmmu page-table walkers.
// Optional PTW_ARB_RR_EN: round-robin tie-break instead of fixed dmmu priority.
module ptw_mem_arbiter
   import ptw_mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
)
(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [1:0]            req,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   output logic [1:0]            ack,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  err,
   output logic                  r_request_valid,
   input  logic                  r_request_ready,
   output logic [ADDR_WIDTH-1:0] r_request_addr,
   input  logic                  r_reply_valid,
   output logic                  r_reply_ready,
   input  logic [DATA_WIDTH-1:0] r_reply_data,
   input  logic [1:0]            r_reply_resp
);

   state_t                state;
   grant_t                grant;
   grant_t                pick_idx;
   grant_t                last;
   logic                  pick_vld;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;

`ifdef PTW_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (!rstn)
         last <= 1'b1;
      else if (state == IDLE && pick_vld)
         last <= pick_idx;
   end
`else
   assign last = 1'b1;
`endif

   ptw_arb_pick u_pick (
      .req       (req),
      .last      (last),
      .grant     (pick_idx),
      .grant_vld (pick_vld)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= IDLE;
         grant   <= 1'b0;
         addr_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (pick_vld) begin
               grant  <= pick_idx;
               addr_q <= pick_idx ? addr1 : addr0;
               state  <= ADDR;
            end
            ADDR: if (r_request_ready) state <= DATA;
            DATA: if (r_reply_valid) begin
               rdata_q <= r_reply_data;
               err_q   <= (r_reply_resp != RESP_OKAY);
               state   <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // All outputs decode registered state, so nothing from req reaches the memory side combinationally.
   assign r_request_valid = (state == ADDR);
   assign r_request_addr  = addr_q;
   assign r_reply_ready   = (state == DATA);
   assign ack             = (state == DONE) ? (grant ? 2'b10 : 2'b01) : 2'b00;
   assign rdata           = rdata_q;
   assign err             = (state == DONE) & err_q;

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Self-checking bench for ptw_mem_arbiter: directed scenarios plus randomized walkers/memory,
// checked every cycle against a timestamp-based transaction model.
module tb_ptw_mem_arbiter;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic [1:0]   req = 2'b00;
   logic [63:0]  addr0 = '0;
   logic [63:0]  addr1 = '0;
   logic [1:0]   ack;
   logic [63:0]  rdata;
   logic         err;
   logic         r_request_valid;
   logic         r_request_ready = 1'b0;
   logic [63:0]  r_request_addr;
   logic         r_reply_valid = 1'b0;
   logic         r_reply_ready;
   logic [63:0]  r_reply_data = '0;
   logic [1:0]   r_reply_resp = 2'b00;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   ptw_mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
      .clk             (clk),
      .rstn            (rstn),
      .req             (req),
      .addr0           (addr0),
      .addr1           (addr1),
      .ack             (ack),
      .rdata           (rdata),
      .err             (err),
      .r_request_valid (r_request_valid),
      .r_request_ready (r_request_ready),
      .r_request_addr  (r_request_addr),
      .r_reply_valid   (r_reply_valid),
      .r_reply_ready   (r_reply_ready),
      .r_reply_data    (r_reply_data),
      .r_reply_resp    (r_reply_resp)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference arbitration rule
   function automatic int model_pick(input logic [1:0] r, input int lst);
`ifdef PTW_ARB_RR_EN
      if (r == 2'b11) return (lst == 0) ? 1 : 0;
`else
      if (r == 2'b11) return 1;
`endif
      return r[1] ? 1 : 0;
   endfunction

   // Transaction model: one outstanding read, described by the edges at which it was
   // granted (m_pick), its address was accepted (m_hs) and its reply arrived (m_rep).
   int          edge_n = 0;
   bit          m_act  = 0;
   int          m_who, m_pick, m_hs, m_rep;
   logic [63:0] m_addr, m_data;
   bit          m_err;
   int          m_free = 0;
   int          m_last = 1;
   int          n_ack  = 0;
   int          ack_edge = -1;
   logic [1:0]  ack_seen = 2'b00;
   logic [63:0] hs_q[$];

   always begin
      logic [1:0] exp_ack;
      bit         exp_rv;
      @(posedge clk);
      edge_n++;
      if (rstn && r_request_valid && r_request_ready) hs_q.push_back(r_request_addr);
      if (!rstn) begin
         m_act  = 0;
         m_free = edge_n + 1;
         m_last = 1;
      end else begin
         if (m_act) begin
            if (m_rep >= 0 && edge_n == m_rep + 1) begin
               m_act  = 0;
               m_free = edge_n + 1;
            end else if (m_hs < 0) begin
               if (r_request_ready) m_hs = edge_n;
            end else if (m_rep < 0 && r_reply_valid) begin
               m_rep  = edge_n;
               m_data = r_reply_data;
               m_err  = (r_reply_resp != 2'b00);
            end
         end
         if (!m_act && edge_n >= m_free && req != 2'b00) begin
            m_who  = model_pick(req, m_last);
            m_last = m_who;
            m_addr = (m_who == 1) ? addr1 : addr0;
            m_pick = edge_n;
            m_hs   = -1;
            m_rep  = -1;
            m_act  = 1;
         end
      end
      #1;
      exp_rv  = m_act && m_hs < 0;
      exp_ack = (m_act && m_rep == edge_n) ? ((m_who == 1) ? 2'b10 : 2'b01) : 2'b00;
      check("req_valid", r_request_valid, exp_rv);
      if (exp_rv) check("req_addr", r_request_addr, m_addr);
      check("reply_ready", r_reply_ready, m_act && m_hs >= 0 && m_rep < 0);
      check("ack", ack, exp_ack);
      if (exp_ack != 2'b00) begin
         check("rdata", rdata, m_data);
         check("err", err, m_err);
      end else begin
         check("err_idle", err, 1'b0);
      end
      ack_seen = ack;
      if (ack != 2'b00) begin
         n_ack++;
         ack_edge = edge_n;
      end
   end

   // One walker transaction: ready held low rdy_lat cycles in ADDR, reply withheld vld_lat cycles in DATA.
   task automatic txn(input logic [1:0] rb, input logic [63:0] a, input int rdy_lat, input int vld_lat,
                      input logic [63:0] d, input logic [1:0] rsp, input bit withdraw,
                      output int lat, output logic [63:0] addr_c1, output logic [1:0] ack_v,
                      output logic [63:0] rd_v, output logic err_v);
      int pick;
      bit done;
      done = 0; lat = -1; addr_c1 = '0; ack_v = '0; rd_v = '0; err_v = 1'b0;
      @(negedge clk);
      pick = edge_n + 1;
      req = rb; addr0 = a; addr1 = a;
      r_request_ready = 1'b0; r_reply_valid = 1'b0;
      r_reply_data = d; r_reply_resp = rsp;
      for (int j = 1; j < 40 && !done; j++) begin
         @(negedge clk);
         if (j == 1) addr_c1 = r_request_valid ? r_request_addr : '0;
         if (ack != 2'b00) begin
            lat = edge_n - pick + 1; ack_v = ack; rd_v = rdata; err_v = err;
            req = 2'b00; done = 1;
         end
         if (withdraw && j == rdy_lat + 2) req = 2'b00;
         r_request_ready = (j >= rdy_lat + 1);
         r_reply_valid   = (j >= rdy_lat + vld_lat + 2);
      end
      req = 2'b00; r_request_ready = 1'b0; r_reply_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int          lat, a_start;
      logic [63:0] c1, rd_v;
      logic [1:0]  ack_v;
      logic        err_v;
      logic [1:0]  wait_w;
      logic [63:0] tie_exp[3];
      int          p_req, p_rdy, p_vld;

      repeat (3) @(negedge clk);
      rstn = 1'b1;
      check("rst_ack", ack, 2'b00);
      check("rst_rdata", rdata, 64'h0);
      check("rst_err", err, 1'b0);
      check("rst_rv", r_request_valid, 1'b0);
      check("rst_rr", r_reply_ready, 1'b0);
      @(negedge clk);

      // Simultaneous requests, immu held throughout, dmmu drops after its ack
`ifdef PTW_ARB_RR_EN
      tie_exp[0] = 64'h1000; tie_exp[1] = 64'h2000; tie_exp[2] = 64'h1000;
`else
      tie_exp[0] = 64'h2000; tie_exp[1] = 64'h1000; tie_exp[2] = 64'h1000;
`endif
      hs_q.delete();
      req = 2'b11; addr0 = 64'h1000; addr1 = 64'h2000;
      r_request_ready = 1'b1; r_reply_valid = 1'b1; r_reply_data = 64'h55; r_reply_resp = 2'b00;
      for (int i = 0; i < 40 && hs_q.size() < 3; i++) begin
         @(negedge clk);
         if (ack_seen[1]) req[1] = 1'b0;
      end
      req = 2'b00;
      repeat (6) @(negedge clk);
      r_request_ready = 1'b0; r_reply_valid = 1'b0;
      @(negedge clk);
      check("tie_cnt", hs_q.size() >= 3, 1'b1);
      for (int i = 0; i < 3; i++)
         check($sformatf("tie_ord%0d", i), (hs_q.size() > i) ? hs_q[i] : 64'h0, tie_exp[i]);

      // Single request, no backpressure
      a_start = n_ack;
      txn(2'b01, 64'h8000_1000, 0, 0, 64'hDEAD_BEEF_0000_0001, 2'b00, 0, lat, c1, ack_v, rd_v, err_v);
      check("s1_addr_c1", c1, 64'h8000_1000);
      check("s1_lat", lat, 3);
      check("s1_ack", ack_v, 2'b01);
      check("s1_rdata", rd_v, 64'hDEAD_BEEF_0000_0001);
      check("s1_err", err_v, 1'b0);
      check("s1_pulses", n_ack - a_start, 1);

      // Backpressure on both handshakes
      a_start = n_ack;
      txn(2'b10, 64'h0000_0042_0000_0ff8, 3, 5, 64'h1234_5678_9abc_def0, 2'b00, 0, lat, c1, ack_v, rd_v, err_v);
      check("bp_lat", lat, 11);
      check("bp_ack", ack_v, 2'b10);
      check("bp_rdata", rd_v, 64'h1234_5678_9abc_def0);
      check("bp_pulses", n_ack - a_start, 1);

      // Error reply
      txn(2'b01, 64'h3000, 1, 1, 64'hE, 2'b10, 0, lat, c1, ack_v, rd_v, err_v);
      check("er_lat", lat, 5);
      check("er_err", err_v, 1'b1);

      // dmmu withdraws during DATA
      a_start = n_ack;
      txn(2'b10, 64'h4000, 0, 2, 64'h77, 2'b00, 1, lat, c1, ack_v, rd_v, err_v);
      check("wd_ack", ack_v, 2'b10);
      check("wd_pulses", n_ack - a_start, 1);
      check("wd_idle_rv", r_request_valid, 1'b0);

      // Reset during ADDR
      @(negedge clk);
      req = 2'b01; addr0 = 64'hA000; r_request_ready = 1'b0; r_reply_valid = 1'b0;
      @(negedge clk);
      check("mr_in_addr", r_request_valid, 1'b1);
      rstn = 1'b0; req = 2'b00;
      @(negedge clk);
      rstn = 1'b1;
      check("mr_rv", r_request_valid, 1'b0);
      check("mr_ack", ack, 2'b00);
      check("mr_rr", r_reply_ready, 1'b0);
      check("mr_rdata", rdata, 64'h0);
      a_start = n_ack;
      txn(2'b01, 64'hB000, 0, 1, 64'hC0FFEE, 2'b00, 0, lat, c1, ack_v, rd_v, err_v);
      check("mr_fresh_lat", lat, 4);
      check("mr_fresh_rdata", rd_v, 64'hC0FFEE);
      check("mr_fresh_pulses", n_ack - a_start, 1);

      // Randomized walkers and memory
      wait_w  = 2'b00;
      a_start = n_ack;
      for (int blk = 0; blk < 8; blk++) begin
         p_req = $urandom_range(10, 90);
         p_rdy = $urandom_range(20, 100);
         p_vld = $urandom_range(20, 100);
         for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if ($urandom_range(599) == 0) begin
               rstn = 1'b0; req = 2'b00; wait_w = 2'b00;
            end else begin
               rstn = 1'b1;
               for (int w = 0; w < 2; w++) begin
                  if (ack_seen[w]) begin
                     req[w] = 1'b0; wait_w[w] = 1'b0;
                  end else if (!req[w] && !wait_w[w] && $urandom_range(99) < p_req) begin
                     if (w == 1) addr1 = {$urandom, $urandom};
                     else        addr0 = {$urandom, $urandom};
                     req[w] = 1'b1; wait_w[w] = 1'b1;
                  end else if (req[w] && m_act && m_who == w && m_hs >= 0 && $urandom_range(99) < 3) begin
                     req[w] = 1'b0;
                  end
               end
            end
            r_request_ready = ($urandom_range(99) < p_rdy);
            r_reply_valid   = ($urandom_range(99) < p_vld);
            r_reply_data    = {$urandom, $urandom};
            r_reply_resp    = ($urandom_range(1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         end
      end
      rstn = 1'b1; req = 2'b00;
      repeat (20) @(negedge clk);
      check("rand_progress", (n_ack - a_start) >= 50, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ptw_mem_arbiter.md
# ptw_mem_arbiter

Shares one read-only memory request channel between the instruction-side and data-side page-table walkers, which today each own a private Core2Mem_FSM/CoreAxi_lite path. The block accepts level-held read requests from both walkers, grants one at a time and drives a single valid/ready request/reply channel toward one CoreAxi_lite master. It returns read data with a one-cycle acknowledge pulse to the granted walker. Only one transaction is ever outstanding.

## Interface
- ADDR_WIDTH, 64: walker and memory address width.
- DATA_WIDTH, 64: read data width (one PTE per beat).
- clk  in  1  system clock; every register updates on the rising edge.
- rstn  in  1  synchronous, active-low reset.
- req  in  2  per-walker read request: [0] immu, [1] dmmu. Held high until the matching ack.
- addr0, addr1  in  ADDR_WIDTH  walker read addresses. Must be stable while req is high.
- ack  out  2  one-cycle pulse to the granted walker. rdata and err are valid in that cycle.
- rdata  out  DATA_WIDTH  read data, shared by both walkers.
- err  out  1  the reply resp was non-zero. Valid only with ack.
- r_request_valid  out  1  read address valid toward memory.
- r_request_ready  in  1  memory accepts the address.
- r_request_addr  out  ADDR_WIDTH  read address.
- r_reply_valid  in  1  read data valid from memory.
- r_reply_ready  out  1  the block accepts read data.
- r_reply_data  in  DATA_WIDTH  read data.
- r_reply_resp  in  2  AXI response code.

## Operation
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - If req is non-zero, pick the grant and latch the grant index and the granted address.
  - Go to ADDR.
- ADDR:
  - r_request_valid=1 and r_request_addr equals the latched address.
  - On r_request_valid & r_request_ready, go to DATA.
- DATA:
  - r_reply_ready=1.
  - On r_reply_valid, latch r_reply_data and the error bit (err = resp != 2'b00), then go to DONE.
- DONE:
  - ack[grant]=1 for exactly one cycle; rdata and err are driven from the latched values.
  - Go to IDLE.
- Addresses are passed through unmodified; the block performs no alignment checks.
- If a walker drops req mid-transaction, the transaction still completes and ack is still pulsed. The walker ignores that pulse.
- A req that is still high in the IDLE cycle after DONE is treated as a new request. Walkers must drop req the cycle after ack.
- Reset values:
  - state=IDLE, grant=0, latched addr=0, rdata=0, err=0, ack=0.
  - r_request_valid=0, r_reply_ready=0.
  - Round-robin pointer last=1.
- Reset asserted mid-operation: the block returns to IDLE next edge and any in-flight reply is dropped. The downstream CoreAxi_lite shares rstn, so no stale beat can reach the block after reset.

## Timing
- Minimum latency: req sampled in IDLE at cycle 0, address handshake at cycle 1, reply at cycle 2, ack at cycle 3.
- Each cycle r_request_ready or r_reply_valid is held low adds one cycle to the latency.
- Back-to-back throughput is one transaction per 4 cycles at minimum, because IDLE is always visited between transactions.
- r_request_valid stays asserted from entry into ADDR until the handshake. r_request_addr is stable for that whole time.
- Outputs are registered (state-decoded). There is no combinational path from req to any memory-side output.

## Configuration
- PTW_ARB_RR_EN defined: round-robin arbitration.
  - On a simultaneous request, the walker not equal to last wins; last updates to the granted index on each grant.
  - After reset (last=1), immu wins the first tie.
- PTW_ARB_RR_EN undefined: fixed priority, dmmu ([1]) always wins ties. The last register is not instantiated.

## Structure
- A shared package PtwArbStruct (header PtwArbStruct.vh) holds:
  - the state enum (IDLE/ADDR/DATA/DONE);
  - the grant index typedef;
  - the RESP_OKAY=2'b00 constant.
- One sub-module, ptw_arb_pick:
  - combinational;
  - inputs: req and last;
  - outputs: the grant index and a grant-valid flag;
  - holds both arbitration policies under the macro.

## Test plan
- Single request, memory always ready with immediate reply:
  - stimulus: req=2'b01, addr0=0x8000_1000, reply 0xDEAD_BEEF_0000_0001 with resp=0;
  - required: r_request_addr=0x8000_1000 at cycle 1, ack=2'b01 at cycle 3, rdata=0xDEAD_BEEF_0000_0001, err=0.
- Simultaneous requests, req=2'b11 held, addr0=0x1000, addr1=0x2000:
  - with RR: grant order is 0x1000, 0x2000, 0x1000;
  - without RR: 0x2000 is served first, then 0x1000 after dmmu drops req.
- Backpressure:
  - stimulus: r_request_ready low for 3 cycles, then r_reply_valid delayed 5 cycles;
  - required: address held stable throughout, ack at cycle 3+3+5=11, exactly one ack pulse.
- Error reply:
  - stimulus: r_reply_resp=2'b10;
  - required: ack pulses with err=1; err=0 outside the ack cycle.
- Request withdrawn:
  - stimulus: req[1] dropped during DATA;
  - required: ack[1] still pulses once and the block is back in IDLE the next cycle.
- Mid-transaction reset:
  - stimulus: rstn low for 1 cycle during ADDR;
  - required: the next cycle has r_request_valid=0, ack=0, state=IDLE; a fresh request then completes normally.
